// File: rtl/coincidence_unit.sv
// Serial address/count coincidence detector for the SCT output stage.
// Compares sct against counter inside the digit window and opens a one-minor-cycle memory select gate on a match.
module coincidence_unit #(
  parameter int DIGITS     = 18,
  parameter int WINDOW_LO  = 2,
  parameter int WINDOW_HI  = 7,
  parameter int MAX_CYCLES = 32
) (
  input  logic clk,
  input  logic reset_neg,
  input  logic g12,
  input  logic ev_d0,
  input  logic sct,
  input  logic counter,
  output logic coinc,
  output logic coinc_gate,
  output logic coinc_miss
);

  localparam int DW = $clog2(DIGITS);
  localparam int CW = $clog2(MAX_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    FOUND  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t        state_q;
  logic [DW-1:0] dig_q;
  logic [DW-1:0] dig;
  logic [DW-1:0] dig_d;
  logic          valid_q;
  logic          mism_q;
  logic [CW-1:0] win_cnt_q;
  logic [CW-1:0] win_inc;
  logic [DW-1:0] gate_cnt_q;
  logic          coinc_q;
  logic          gate_q;
  logic          miss_q;
  logic          diff;

  // dig is the digit of the current clock: ev_d0 forces digit 0 in its own cycle
  assign dig     = ev_d0 ? '0 : dig_q;
  assign dig_d   = (dig == DW'(DIGITS - 1)) ? '0 : dig + 1'b1;
  assign diff    = sct ^ counter;
  assign win_inc = (win_cnt_q == CW'(MAX_CYCLES)) ? win_cnt_q : win_cnt_q + 1'b1;

  always_ff @(posedge clk or negedge reset_neg) begin
    if (!reset_neg) begin
      dig_q <= '0;
    end else begin
      dig_q <= dig_d;
    end
  end

  always_ff @(posedge clk or negedge reset_neg) begin
    if (!reset_neg) begin
      state_q    <= IDLE;
      valid_q    <= 1'b0;
      mism_q     <= 1'b0;
      win_cnt_q  <= '0;
      gate_cnt_q <= '0;
      coinc_q    <= 1'b0;
      gate_q     <= 1'b0;
      miss_q     <= 1'b0;
    end else begin
      coinc_q <= 1'b0;
      if (!g12) begin
        state_q    <= IDLE;
        valid_q    <= 1'b0;
        mism_q     <= 1'b0;
        win_cnt_q  <= '0;
        gate_cnt_q <= '0;
        gate_q     <= 1'b0;
        miss_q     <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            valid_q   <= 1'b0;
            mism_q    <= 1'b0;
            win_cnt_q <= '0;
            gate_q    <= 1'b0;
            miss_q    <= 1'b0;
            state_q   <= SEARCH;
          end
          SEARCH: begin
            // valid is only ever set here, so a window entered past WINDOW_LO is never decided
            if (dig == DW'(WINDOW_LO)) begin
              valid_q <= 1'b1;
              mism_q  <= diff;
            end else if (dig > DW'(WINDOW_LO) && dig < DW'(WINDOW_HI)) begin
              if (diff) mism_q <= 1'b1;
            end else if (dig == DW'(WINDOW_HI) && valid_q) begin
              if (!mism_q) begin
                state_q <= FOUND;
                coinc_q <= 1'b1;
              end else begin
                valid_q   <= 1'b0;
                win_cnt_q <= win_inc;
                if (win_inc == CW'(MAX_CYCLES)) begin
                  miss_q  <= 1'b1;
                  state_q <= DONE;
                end
              end
            end
          end
          FOUND: begin
            if (!gate_q) begin
              if (ev_d0) begin
                gate_q     <= 1'b1;
                gate_cnt_q <= DW'(DIGITS - 1);
              end
            end else if (gate_cnt_q == '0) begin
              gate_q  <= 1'b0;
              state_q <= DONE;
            end else begin
              gate_cnt_q <= gate_cnt_q - 1'b1;
            end
          end
          DONE: begin
            gate_q <= 1'b0;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign coinc      = coinc_q;
  assign coinc_gate = gate_q;
  assign coinc_miss = miss_q;

endmodule

// File: tb/tb_coincidence_unit.sv
// Directed bench for coincidence_unit: digit-accurate stimulus with hand-computed coinc/gate/miss timing.
module tb_coincidence_unit;

  logic clk = 1'b0;
  logic reset_neg = 1'b0;
  logic g12 = 1'b0;
  logic ev_d0 = 1'b0;
  logic sct = 1'b0;
  logic counter = 1'b0;
  logic coinc, coinc_gate, coinc_miss;

  int n_tests = 0;
  int n_fail = 0;

  int td = 0;
  int coinc_n, coinc_dig, gate_n, gate_first;
  logic [17:0] s_pat = '0;
  logic [17:0] c_pat = '0;

  coincidence_unit dut (
    .clk        (clk),
    .reset_neg  (reset_neg),
    .g12        (g12),
    .ev_d0      (ev_d0),
    .sct        (sct),
    .counter    (counter),
    .coinc      (coinc),
    .coinc_gate (coinc_gate),
    .coinc_miss (coinc_miss)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr_obs();
    coinc_n = 0;
    coinc_dig = -1;
    gate_n = 0;
    gate_first = -1;
  endtask

  // drive one digit, then observe the outputs of the following digit (td after increment)
  task automatic tick(input bit e0);
    if (e0) td = 0;
    ev_d0 = e0;
    sct = s_pat[td];
    counter = c_pat[td];
    @(posedge clk);
    #1;
    td = (td == 17) ? 0 : td + 1;
    if (coinc === 1'b1) begin
      coinc_n++;
      coinc_dig = td;
    end
    if (coinc_gate === 1'b1) begin
      if (gate_n == 0) gate_first = td;
      gate_n++;
    end
  endtask

  task automatic mcyc();
    for (int i = 0; i < 18; i++) tick(i == 0);
  endtask

  task automatic run_to(input int d);
    for (int i = 0; i < 18 && td != d; i++) tick(td == 0);
  endtask

  task automatic check_quiet(input string tag);
    check_val(tag, int'({coinc, coinc_gate, coinc_miss}), 0);
  endtask

  initial begin
    clr_obs();
    #12;
    check_quiet("reset outs");
    check_val("reset state", int'(dut.state_q), 0);
    reset_neg = 1'b1;
    @(posedge clk);
    #1;
    mcyc();
    check_quiet("idle outs");

    // match in first window
    s_pat = 18'h00034;
    c_pat = 18'h00034;
    g12 = 1'b1;
    clr_obs();
    mcyc();
    check_val("t1 coinc count", coinc_n, 1);
    check_val("t1 coinc digit", coinc_dig, 8);
    check_val("t1 gate early", gate_n, 0);
    mcyc();
    mcyc();
    check_val("t1 gate clocks", gate_n, 18);
    check_val("t1 gate first digit", gate_first, 1);
    check_val("t1 coinc single", coinc_n, 1);
    check_val("t1 miss", int'(coinc_miss), 0);
    check_val("t1 state done", int'(dut.state_q), 3);
    g12 = 1'b0;
    mcyc();
    check_quiet("t1 idle outs");

    // single-bit mismatch at d4, then match
    c_pat = 18'h00024;
    g12 = 1'b1;
    clr_obs();
    mcyc();
    check_val("t2 no coinc cycle1", coinc_n, 0);
    c_pat = 18'h00034;
    mcyc();
    check_val("t2 coinc count", coinc_n, 1);
    check_val("t2 coinc digit", coinc_dig, 8);
    check_val("t2 window count", int'(dut.win_cnt_q), 1);
    g12 = 1'b0;
    mcyc();

    // persistent mismatch -> miss after 32 windows
    s_pat = 18'h3FFFF;
    c_pat = 18'h00000;
    g12 = 1'b1;
    clr_obs();
    repeat (31) mcyc();
    check_val("t3 miss after 31", int'(coinc_miss), 0);
    check_val("t3 window count 31", int'(dut.win_cnt_q), 31);
    tick(1'b1);
    repeat (6) tick(1'b0);
    check_val("t3 miss before 32nd decision", int'(coinc_miss), 0);
    tick(1'b0);
    check_val("t3 miss at d8", int'(coinc_miss), 1);
    run_to(0);
    mcyc();
    mcyc();
    check_val("t3 miss held", int'(coinc_miss), 1);
    check_val("t3 window count sat", int'(dut.win_cnt_q), 32);
    check_val("t3 no coinc", coinc_n, 0);
    check_val("t3 state done", int'(dut.state_q), 3);
    g12 = 1'b0;
    mcyc();
    check_val("t3 miss cleared", int'(coinc_miss), 0);

    // differences only outside the window
    s_pat = 18'h00000;
    c_pat = 18'h3FF83;
    g12 = 1'b1;
    clr_obs();
    mcyc();
    check_val("t4 coinc count", coinc_n, 1);
    check_val("t4 coinc digit", coinc_dig, 8);
    g12 = 1'b0;
    mcyc();

    // late enable at d4, then ev_d0 resync at digit 9
    s_pat = 18'h00034;
    c_pat = 18'h00034;
    clr_obs();
    tick(1'b1);
    repeat (3) tick(1'b0);
    g12 = 1'b1;
    run_to(0);
    check_val("t5 partial ignored", coinc_n, 0);
    c_pat = 18'h0003C;
    tick(1'b1);
    repeat (8) tick(1'b0);
    check_val("t5 mismatch window", coinc_n, 0);
    check_val("t5 window count", int'(dut.win_cnt_q), 1);
    c_pat = 18'h00034;
    tick(1'b1);
    run_to(0);
    check_val("t5 resync coinc count", coinc_n, 1);
    check_val("t5 resync coinc digit", coinc_dig, 8);
    g12 = 1'b0;
    mcyc();

    // abort 5 clocks into the gate
    clr_obs();
    g12 = 1'b1;
    mcyc();
    tick(1'b1);
    repeat (4) tick(1'b0);
    check_val("t6 gate clocks before abort", gate_n, 5);
    g12 = 1'b0;
    tick(1'b0);
    check_val("t6 gate after abort", int'(coinc_gate), 0);
    check_val("t6 state idle", int'(dut.state_q), 0);
    run_to(0);

    // async reset mid-search
    s_pat = 18'h00000;
    c_pat = 18'h3FF83;
    g12 = 1'b1;
    clr_obs();
    tick(1'b1);
    repeat (4) tick(1'b0);
    check_val("t7 state search", int'(dut.state_q), 1);
    reset_neg = 1'b0;
    #2;
    check_quiet("t7 reset outs");
    check_val("t7 reset state", int'(dut.state_q), 0);
    reset_neg = 1'b1;
    run_to(0);
    check_val("t7 no coinc after release", coinc_n, 0);
    mcyc();
    check_val("t7 coinc count", coinc_n, 1);
    check_val("t7 coinc digit", coinc_dig, 8);
    g12 = 1'b0;
    mcyc();
    check_quiet("t7 final outs");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
